// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: FSM states, fill owner
// encoding, block geometry and the fixed memory read latency.
package cache_fill_arbiter_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = 3;
    localparam int MEM_LATENCY = 4;

    // Clears the byte-in-block bits: addr & ~(2*BLOCK_WORDS-1)
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Byte address of a word within a block: base + {word, 1'b0}
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                    input logic [WORD_IDX_W-1:0] word);
        return base + {{(ADDR_W - WORD_IDX_W - 1){1'b0}}, word, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// fill_word_counter: 3-bit loadable word index that increments and wraps
// modulo 8, with a separate beat count that flags the last (8th) beat and
// saturates at "all 8 beats done".
module fill_word_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [WORD_IDX_W-1:0] i_start,
    input  logic                  i_inc,
    output logic [WORD_IDX_W-1:0] o_word,
    output logic                  o_last,
    output logic                  o_done
);

    logic [WORD_IDX_W-1:0] r_word;
    logic [WORD_IDX_W:0]   r_count;

    assign o_word = r_word;
    assign o_last = (r_count == (WORD_IDX_W + 1)'(BLOCK_WORDS - 1));
    assign o_done = (r_count == (WORD_IDX_W + 1)'(BLOCK_WORDS));

    // Word index and beat count: load on grant, advance once per beat
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= i_start;
            r_count <= '0;
        end else if (i_inc && !o_done) begin
            r_word  <= r_word + WORD_IDX_W'(1);
            r_count <= r_count + (WORD_IDX_W + 1)'(1);
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: serializes I-cache / D-cache block fills and D-cache
// write-through stores onto the single shared memory port.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (fill starts at the missed
// word and wraps); undefined, every fill starts at word 0.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_miss_addr,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_miss_addr,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ic_fill_we,
    output logic              dc_fill_we,
    output logic [2:0]        fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              ic_fill_done,
    output logic              dc_fill_done,
    output logic              dc_wr_ack
);

    state_t                r_state;
    state_t                w_next_state;
    owner_t                r_owner;
    logic [ADDR_W-1:0]     r_base;

    logic                  w_miss_grant;
    owner_t                w_grant_owner;
    logic [ADDR_W-1:0]     w_grant_addr;
    logic [WORD_IDX_W-1:0] w_start;

    logic [WORD_IDX_W-1:0] w_issue_word;
    logic                  w_issue_done;
    logic                  w_unused_issue_last;
    logic [WORD_IDX_W-1:0] w_recv_word;
    logic                  w_recv_last;
    logic                  w_recv_done;

    logic                  w_issue;
    logic                  w_fill_valid;

    // Reads issue for 8 cycles in FILL; returning data is only accepted in
    // FILL and never past the 8th word.
    assign w_issue      = (r_state == FILL) && !w_issue_done;
    assign w_fill_valid = (r_state == FILL) && mem_valid && !w_recv_done;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = w_grant_addr[WORD_IDX_W:1];
`else
    assign w_start = '0;
`endif

    fill_word_counter u_issue_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_miss_grant),
        .i_start (w_start),
        .i_inc   (w_issue),
        .o_word  (w_issue_word),
        .o_last  (w_unused_issue_last),
        .o_done  (w_issue_done)
    );

    fill_word_counter u_recv_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_miss_grant),
        .i_start (w_start),
        .i_inc   (w_fill_valid),
        .o_word  (w_recv_word),
        .o_last  (w_recv_last),
        .o_done  (w_recv_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner and block base captured at the miss grant; held for the whole fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IC;
            r_base  <= '0;
        end else if (w_miss_grant) begin
            r_owner <= w_grant_owner;
            r_base  <= w_grant_addr & BLOCK_MASK;
        end
    end

    // Fixed-priority grant, next state and memory/cache strobes
    // NOTE: every signal gets a default before the case so no path through
    // this block can hold a stale value (which would infer a latch).
    always_comb begin
        w_next_state  = r_state;
        w_miss_grant  = 1'b0;
        w_grant_owner = OWN_IC;
        w_grant_addr  = ic_miss_addr;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        ic_fill_we    = 1'b0;
        dc_fill_we    = 1'b0;
        fill_word     = '0;
        fill_data     = '0;
        ic_fill_done  = 1'b0;
        dc_fill_done  = 1'b0;
        dc_wr_ack     = 1'b0;

        case (r_state)
            IDLE: begin
                // D side first: it belongs to the older instruction
                if (dc_miss) begin
                    w_next_state  = FILL;
                    w_miss_grant  = 1'b1;
                    w_grant_owner = OWN_DC;
                    w_grant_addr  = dc_miss_addr;
                end else if (dc_wr_req) begin
                    w_next_state  = WRITE;
                end else if (ic_miss) begin
                    w_next_state  = FILL;
                    w_miss_grant  = 1'b1;
                    w_grant_owner = OWN_IC;
                    w_grant_addr  = ic_miss_addr;
                end
            end

            FILL: begin
                mem_rd = w_issue;
                if (w_issue) begin
                    mem_addr = word_addr(r_base, w_issue_word);
                end
                if (w_fill_valid) begin
                    fill_word = w_recv_word;
                    fill_data = mem_rdata;
                    if (r_owner == OWN_DC) begin
                        dc_fill_we   = 1'b1;
                        dc_fill_done = w_recv_last;
                    end else begin
                        ic_fill_we   = 1'b1;
                        ic_fill_done = w_recv_last;
                    end
                    if (w_recv_last) begin
                        w_next_state = IDLE;
                    end
                end
            end

            WRITE: begin
                mem_wr       = 1'b1;
                mem_addr     = dc_wr_addr;
                mem_wdata    = dc_wr_data;
                dc_wr_ack    = 1'b1;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Testbench for cache_fill_arbiter. A behavioural model predicts, per cycle,
// every memory and cache strobe from the request rules; a monitor compares
// the DUT against that queue. Honours CRITICAL_WORD_FIRST_EN when defined.
`timescale 1ns/1ps
module tb_cache_fill_arbiter;
    import cache_fill_arbiter_pkg::*;

    localparam int K_IC = 0;
    localparam int K_DC = 1;
    localparam int K_WR = 2;
    localparam int WAIT_BUDGET = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_miss = 1'b0;
    logic [15:0] ic_miss_addr = '0;
    logic        dc_miss = 1'b0;
    logic [15:0] dc_miss_addr = '0;
    logic        dc_wr_req = 1'b0;
    logic [15:0] dc_wr_addr = '0;
    logic [15:0] dc_wr_data = '0;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        ic_fill_we, dc_fill_we;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        ic_fill_done, dc_fill_done, dc_wr_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int free_at  = 0;

    cache_fill_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ic_miss      (ic_miss),
        .ic_miss_addr (ic_miss_addr),
        .dc_miss      (dc_miss),
        .dc_miss_addr (dc_miss_addr),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_data   (dc_wr_data),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_valid    (mem_valid),
        .mem_rdata    (mem_rdata),
        .ic_fill_we   (ic_fill_we),
        .dc_fill_we   (dc_fill_we),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .ic_fill_done (ic_fill_done),
        .dc_fill_done (dc_fill_done),
        .dc_wr_ack    (dc_wr_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Memory contents are a fixed hash of the address
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'd40503;
        return t ^ 16'h3C5A;
    endfunction

    // Memory model: read data returns MEM_LATENCY cycles after mem_rd
    logic [MEM_LATENCY-1:0] pipe_v;
    logic [15:0]            pipe_a [MEM_LATENCY];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) pipe_a[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[MEM_LATENCY-2:0], mem_rd};
            pipe_a[0] <= mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign mem_valid = pipe_v[MEM_LATENCY-1];
    assign mem_rdata = mem_valid ? mem_word(pipe_a[MEM_LATENCY-1]) : 16'hDEAD;

    // Expected per-cycle activity
    typedef struct {
        int          cyc;
        logic        rd, wr;
        logic [15:0] addr, wdata;
        logic        ic_we, dc_we;
        logic [2:0]  word;
        logic [15:0] data;
        logic        ic_done, dc_done, ack;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_fill(input bit is_dc, input logic [15:0] a, input int g);
        logic [15:0] base;
        int          start;
        int          w;
        exp_t        e;
        base = a & ~16'(2 * BLOCK_WORDS - 1);
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(a[3:1]);
`else
        start = 0;
`endif
        for (int k = 1; k <= 4 + BLOCK_WORDS; k++) begin
            e = '{default: '0};
            e.cyc = g + k;
            if (k <= BLOCK_WORDS) begin
                e.rd   = 1'b1;
                e.addr = base + 16'(2 * ((start + k - 1) % BLOCK_WORDS));
            end
            if (k > MEM_LATENCY) begin
                w       = (start + k - 1 - MEM_LATENCY) % BLOCK_WORDS;
                e.ic_we = !is_dc;
                e.dc_we = is_dc;
                e.word  = 3'(w);
                e.data  = mem_word(base + 16'(2 * w));
                if (k == MEM_LATENCY + BLOCK_WORDS) begin
                    e.ic_done = !is_dc;
                    e.dc_done = is_dc;
                end
            end
            exp_q.push_back(e);
        end
        free_at = g + MEM_LATENCY + BLOCK_WORDS + 1;
    endtask

    task automatic push_store(input logic [15:0] a, input logic [15:0] d, input int g);
        exp_t e;
        e = '{default: '0};
        e.cyc   = g + 1;
        e.wr    = 1'b1;
        e.addr  = a;
        e.wdata = d;
        e.ack   = 1'b1;
        exp_q.push_back(e);
        free_at = g + 2;
    endtask

    // Reference model: whenever the port is free, grant by fixed priority
    always @(negedge clk) begin
        if (!rst_n) begin
            free_at = 0;
        end else if (cyc >= free_at) begin
            if (dc_miss)        push_fill(1'b1, dc_miss_addr, cyc);
            else if (dc_wr_req) push_store(dc_wr_addr, dc_wr_data, cyc);
            else if (ic_miss)   push_fill(1'b0, ic_miss_addr, cyc);
        end
    end

    logic any_strobe;
    assign any_strobe = mem_rd | mem_wr | ic_fill_we | dc_fill_we |
                        ic_fill_done | dc_fill_done | dc_wr_ack;

    // Monitor: compare DUT activity against the expected queue every cycle
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_beat cyc=%0d: beat never compared, wanted at cyc %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e   = exp_q.pop_front();
                bad = (mem_rd !== e.rd) || (mem_wr !== e.wr) ||
                      (ic_fill_we !== e.ic_we) || (dc_fill_we !== e.dc_we) ||
                      (ic_fill_done !== e.ic_done) || (dc_fill_done !== e.dc_done) ||
                      (dc_wr_ack !== e.ack);
                if ((e.rd || e.wr) && mem_addr !== e.addr) bad = 1'b1;
                if (e.wr && mem_wdata !== e.wdata) bad = 1'b1;
                if ((e.ic_we || e.dc_we) && (fill_word !== e.word || fill_data !== e.data)) bad = 1'b1;
                n_checks++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL beat cyc=%0d got rd=%b wr=%b addr=%h wd=%h icwe=%b dcwe=%b w=%0d d=%h icd=%b dcd=%b ack=%b | want rd=%b wr=%b addr=%h wd=%h icwe=%b dcwe=%b w=%0d d=%h icd=%b dcd=%b ack=%b",
                             cyc, mem_rd, mem_wr, mem_addr, mem_wdata, ic_fill_we, dc_fill_we,
                             fill_word, fill_data, ic_fill_done, dc_fill_done, dc_wr_ack,
                             e.rd, e.wr, e.addr, e.wdata, e.ic_we, e.dc_we, e.word, e.data,
                             e.ic_done, e.dc_done, e.ack);
                end
            end else begin
                n_checks++;
                if (any_strobe) begin
                    n_fail++;
                    $display("FAIL idle_quiet cyc=%0d got rd=%b wr=%b icwe=%b dcwe=%b icd=%b dcd=%b ack=%b, want all 0",
                             cyc, mem_rd, mem_wr, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack);
                end
            end
        end
    end

    task automatic drop_req(input int kind);
        case (kind)
            K_IC:    ic_miss   = 1'b0;
            K_DC:    dc_miss   = 1'b0;
            default: dc_wr_req = 1'b0;
        endcase
    endtask

    // Requester: raise, hold until done/ack (optionally drop early), then drop
    task automatic req(input int kind, input logic [15:0] a, input logic [15:0] d, input int drop_after);
        bit seen;
        seen = 1'b0;
        case (kind)
            K_IC:    begin ic_miss_addr = a; ic_miss = 1'b1; end
            K_DC:    begin dc_miss_addr = a; dc_miss = 1'b1; end
            default: begin dc_wr_addr = a; dc_wr_data = d; dc_wr_req = 1'b1; end
        endcase
        for (int n = 0; n < WAIT_BUDGET; n++) begin
            @(negedge clk);
            if ((kind == K_IC && ic_fill_done) || (kind == K_DC && dc_fill_done) ||
                (kind == K_WR && dc_wr_ack)) begin
                seen = 1'b1;
                break;
            end
            if (drop_after > 0 && n == drop_after - 1) begin
                @(posedge clk); #1;
                drop_req(kind);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL handshake kind=%0d addr=%h: got no done/ack in %0d cycles, want one", kind, a, WAIT_BUDGET);
        end
        @(posedge clk); #1;
        drop_req(kind);
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] v;
        v = {mem_rd, mem_wr, mem_addr, mem_wdata, ic_fill_we, dc_fill_we,
             fill_word, ic_fill_done, dc_fill_done, dc_wr_ack};
        n_checks++;
        if (v != '0 || fill_data != '0) begin
            n_fail++;
            $display("FAIL %s: got outputs %h fill_data %h, want all 0", tag, v, fill_data);
        end
    endtask

    initial begin
        #1;
        check_all_zero("reset_outputs");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single I-cache miss
        req(K_IC, 16'h1234, 16'h0, 0);

        // Simultaneous misses: D fill first, then I fill
        fork
            req(K_IC, 16'h1000, 16'h0, 0);
            req(K_DC, 16'h0046, 16'h0, 0);
        join

        // Store alongside an I miss: store first
        fork
            req(K_WR, 16'h2002, 16'hBEEF, 0);
            req(K_IC, 16'h3010, 16'h0, 0);
        join

        // Miss in the middle of a block (wraps under critical-word-first)
        req(K_DC, 16'h001A, 16'h0, 0);

        // Requester drops its miss mid-fill
        req(K_IC, 16'h4444, 16'h0, 3);

        // Reset in the middle of a fill, then a fresh miss
        ic_miss_addr = 16'h5556;
        ic_miss = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        ic_miss = 1'b0;
        #1;
        check_all_zero("reset_mid_fill");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        req(K_IC, 16'h5556, 16'h0, 0);

        // Randomized contention among all three requesters
        for (int r = 0; r < 40; r++) begin
            fork
                begin
                    if ($urandom_range(0, 2) != 0) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        req(K_IC, 16'($urandom), 16'h0, 0);
                    end
                end
                begin
                    if ($urandom_range(0, 2) != 0) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        req(K_DC, 16'($urandom), 16'h0, 0);
                    end
                end
                begin
                    if ($urandom_range(0, 2) != 0) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        req(K_WR, 16'($urandom), 16'($urandom), 0);
                    end
                end
            join
        end

        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expected beats left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequences the single shared 16-bit main memory between the I-cache and the D-cache in the pipelined CPU. It serializes block fills (8 words) for I-cache and D-cache misses and single-word write-through stores from the D-cache. It sits between both cache controllers and the multi-cycle memory model. The pipeline's stall logic holds IF or MEM while the corresponding miss is outstanding.

## Interface
- ADDR_W, 16, byte-address width
- BLOCK_WORDS, 8, 16-bit words per cache block (16-byte blocks)
---
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic_miss  in  1  I-cache miss request; held until ic_fill_done
- ic_miss_addr  in  ADDR_W  I-cache miss byte address
- dc_miss  in  1  D-cache miss request; held until dc_fill_done
- dc_miss_addr  in  ADDR_W  D-cache miss byte address
- dc_wr_req  in  1  D-cache write-through store request; held until dc_wr_ack
- dc_wr_addr, dc_wr_data  in  ADDR_W, 16  store address and data
- mem_rd, mem_wr  out  1  memory read / write enable, one cycle per word
- mem_addr, mem_wdata  out  ADDR_W, 16  memory address and write data
- mem_valid  in  1  read data valid; fixed 4 cycles after mem_rd
- mem_rdata  in  16  read data
- ic_fill_we, dc_fill_we  out  1  write fill_data into the owning cache data array
- fill_word  out  3  word index within the block for the current fill_we
- fill_data  out  16  mem_rdata passed through
- ic_fill_done, dc_fill_done  out  1  one-cycle pulse with the last word; cache writes tag and valid
- dc_wr_ack  out  1  one-cycle pulse in the cycle the store is driven to memory

## Operation
- States: IDLE, FILL, WRITE.
- Reset value of every output is 0. Reset clears state to IDLE, clears the owner, and clears both counters.
- In IDLE, the arbiter evaluates requests with fixed priority: dc_miss > dc_wr_req > ic_miss. The D side wins because it is the older instruction.
- On a miss grant:
  - Latch the owner (IC/DC) and the block base address, addr & ~(2*BLOCK_WORDS-1).
  - Go to FILL.
- On a store grant, go to WRITE.
- FILL:
  - The issue counter drives mem_rd for 8 consecutive cycles. mem_addr = base + {word,1'b0}.
  - The receive counter advances on each mem_valid. Each valid word asserts the owner's fill_we, with fill_word set to the receive counter.
  - On the 8th valid word, assert the owner's fill_done in the same cycle, then go to IDLE.
- WRITE: one cycle.
  - Drive mem_wr, mem_addr = dc_wr_addr, mem_wdata = dc_wr_data.
  - Pulse dc_wr_ack.
  - Return to IDLE.
- mem_valid is ignored outside FILL. mem_rd and mem_wr are never asserted in the same cycle.
- Requester deasserts its miss mid-fill: the fill completes anyway and fill_done still pulses. The latched address and owner are unaffected by input changes.
- A requester must drop its request the cycle after done or ack. If it is still high in IDLE, it is treated as a new request.
- ic_miss and dc_miss asserted together: the D fill runs first, then the I fill. No starvation bound is needed, because the pipeline stalls MEM-side misses.
- The memory shares rst_n, so there are no stale mem_valid pulses after reset. Reset mid-FILL abandons the fill with no done pulse.

## Timing
- Grant decided at edge T (IDLE).
- mem_rd asserted in cycles T+1 … T+8.
- mem_valid in cycles T+5 … T+12.
- fill_done in cycle T+12; IDLE in T+13. The next grant can issue mem_rd at T+14.
- Miss service is 12 cycles from the grant edge.
- Store: WRITE in T+1 with dc_wr_ack; IDLE at T+2.
- The issue counter and receive counter are each 3 bits and wrap modulo 8.

## Configuration
- CRITICAL_WORD_FIRST_EN:
  - Defined: issue and receive start at word = miss_addr[3:1] and wrap modulo 8. fill_word follows that order.
  - Undefined: the fill always starts at word 0, ascending.
- Completion is counted (8 words) in both cases. fill_done always accompanies the 8th word.

## Structure
- Shared package holds:
  - the state enum (IDLE/FILL/WRITE)
  - the owner encoding (OWN_IC=0, OWN_DC=1)
  - BLOCK_WORDS and the fixed MEM_LATENCY=4 constant (bench use)
- One natural sub-module: fill_word_counter. It is a 3-bit loadable start index with increment-and-wrap and a count-of-8 terminal flag. It is instantiated twice, once for issue and once for receive.

## Test plan
- ic_miss, addr 0x1234, idle:
  - mem_rd at addresses 0x1230..0x123E over 8 cycles
  - ic_fill_we × 8
  - ic_fill_done at grant+12
  - no dc_* activity
- ic_miss and dc_miss (0x0046) in the same cycle:
  - DC fill (base 0x0040) completes with dc_fill_done at T+12
  - IC grant at T+13
- dc_wr_req 0x2002/0xBEEF alongside ic_miss:
  - mem_wr with 0x2002/0xBEEF and dc_wr_ack at T+1
  - IC fill granted at T+2
- CRITICAL_WORD_FIRST_EN, dc_miss 0x001A:
  - fill_word sequence 5,6,7,0,1,2,3,4
  - addresses 0x001A…0x001E, 0x0010…0x0018
- rst_n low at grant+6 during a fill:
  - all outputs 0 immediately
  - no done pulse
  - a fresh miss after release restarts at its first word
- ic_miss dropped at grant+3: all 8 words are still written and ic_fill_done still pulses.
